// File: rtl/reorder_buffer.sv
// 8-entry circular reorder buffer: tail allocation, CDB capture, same-cycle CDB-bypassed lookups, in-order retire.
// Commit is registered (one cycle after the head becomes ready); rob_full stalls the decoder and dec_en is ignored while full.
module reorder_buffer #(
  parameter int IDX_W  = 3,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              dec_en,
  input  logic [REG_W-1:0]  dec_rd,
  output logic [IDX_W-1:0]  rob_tail,
  output logic              rob_full,
  output logic              rob_empty,
  input  logic [TAG_W-1:0]  tag_check1,
  input  logic [TAG_W-1:0]  tag_check2,
  input  logic [TAG_W-1:0]  tag_checkd,
  output logic              tag1_ready,
  output logic              tag2_ready,
  output logic              tagd_ready,
  output logic [DATA_W-1:0] rob_data1,
  output logic [DATA_W-1:0] rob_data2,
  output logic [DATA_W-1:0] rob_datad,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              commit_en,
  output logic [REG_W-1:0]  commit_reg,
  output logic [DATA_W-1:0] commit_data,
  output logic [TAG_W-1:0]  commit_tag
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [IDX_W:0]   CNT_ONE = 1;
  localparam logic [IDX_W-1:0] IDX_ONE = 1;

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  ready_q, ready_d;
  logic [REG_W-1:0]  rd_q   [DEPTH];
  logic [REG_W-1:0]  rd_d   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [IDX_W-1:0]  head_q, head_d;
  logic [IDX_W-1:0]  tail_q, tail_d;
  logic [IDX_W:0]    count_q, count_d;
  logic              commit_en_q, commit_en_d;
  logic [REG_W-1:0]  commit_reg_q, commit_reg_d;
  logic [DATA_W-1:0] commit_data_q, commit_data_d;
  logic [TAG_W-1:0]  commit_tag_q, commit_tag_d;

  logic              alloc;
  logic              retire;
  logic              cdb_hit;
  logic [IDX_W-1:0]  cdb_idx;

  // Count never exceeds DEPTH, so its MSB alone means full.
  assign rob_full  = count_q[IDX_W];
  assign rob_empty = (count_q == '0);
  assign rob_tail  = tail_q;

  assign cdb_idx = cdb_tag[IDX_W-1:0];
  assign alloc   = dec_en && !rob_full;
  assign retire  = valid_q[head_q] && ready_q[head_q];
  assign cdb_hit = cdb_valid && !cdb_tag[TAG_W-1] && valid_q[cdb_idx];

  // Lookup result packed as {ready, data}; a same-cycle CDB broadcast wins over stored data.
  function automatic logic [DATA_W:0] lookup(input logic [TAG_W-1:0] t);
    logic [IDX_W-1:0] i;
    logic [DATA_W:0]  r;
    i = t[IDX_W-1:0];
    r = '0;
    if (!t[TAG_W-1]) begin
      if (cdb_valid && (cdb_tag == t)) begin
        r = {1'b1, cdb_data};
      end else if (ready_q[i]) begin
        r = {1'b1, data_q[i]};
      end
    end
    return r;
  endfunction

  assign {tag1_ready, rob_data1} = lookup(tag_check1);
  assign {tag2_ready, rob_data2} = lookup(tag_check2);
  assign {tagd_ready, rob_datad} = lookup(tag_checkd);

  always_comb begin
    valid_d       = valid_q;
    ready_d       = ready_q;
    rd_d          = rd_q;
    data_d        = data_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    commit_en_d   = 1'b0;
    commit_reg_d  = commit_reg_q;
    commit_data_d = commit_data_q;
    commit_tag_d  = commit_tag_q;

    if (flush) begin
      valid_d = '0;
      ready_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (cdb_hit) begin
        ready_d[cdb_idx] = 1'b1;
        data_d[cdb_idx]  = cdb_data;
      end
      // Retire uses the pre-edge ready bit, so a CDB write is visible to commit one edge later.
      if (retire) begin
        valid_d[head_q] = 1'b0;
        ready_d[head_q] = 1'b0;
        data_d[head_q]  = '0;
        head_d          = head_q + IDX_ONE;
        commit_en_d     = (rd_q[head_q] != '0);
        commit_reg_d    = rd_q[head_q];
        commit_data_d   = data_q[head_q];
        commit_tag_d    = {1'b0, head_q};
      end
      if (alloc) begin
        valid_d[tail_q] = 1'b1;
        ready_d[tail_q] = 1'b0;
        rd_d[tail_q]    = dec_rd;
        data_d[tail_q]  = '0;
        tail_d          = tail_q + IDX_ONE;
      end
      case ({alloc, retire})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q       <= '0;
      ready_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      commit_en_q   <= 1'b0;
      commit_reg_q  <= '0;
      commit_data_q <= '0;
      commit_tag_q  <= '0;
    end else begin
      valid_q       <= valid_d;
      ready_q       <= ready_d;
      rd_q          <= rd_d;
      data_q        <= data_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      commit_en_q   <= commit_en_d;
      commit_reg_q  <= commit_reg_d;
      commit_data_q <= commit_data_d;
      commit_tag_q  <= commit_tag_d;
    end
  end

  assign commit_en   = commit_en_q;
  assign commit_reg  = commit_reg_q;
  assign commit_data = commit_data_q;
  assign commit_tag  = commit_tag_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: program-order queue model, randomized and directed traffic.
module tb_reorder_buffer;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        dec_en;
  logic [4:0]  dec_rd;
  logic [2:0]  rob_tail;
  logic        rob_full, rob_empty;
  logic [3:0]  tag_check1, tag_check2, tag_checkd;
  logic        tag1_ready, tag2_ready, tagd_ready;
  logic [31:0] rob_data1, rob_data2, rob_datad;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        commit_en;
  logic [4:0]  commit_reg;
  logic [31:0] commit_data;
  logic [3:0]  commit_tag;

  reorder_buffer dut (
    .clk(clk), .rst(rst), .flush(flush), .dec_en(dec_en), .dec_rd(dec_rd),
    .rob_tail(rob_tail), .rob_full(rob_full), .rob_empty(rob_empty),
    .tag_check1(tag_check1), .tag_check2(tag_check2), .tag_checkd(tag_checkd),
    .tag1_ready(tag1_ready), .tag2_ready(tag2_ready), .tagd_ready(tagd_ready),
    .rob_data1(rob_data1), .rob_data2(rob_data2), .rob_datad(rob_datad),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .commit_en(commit_en), .commit_reg(commit_reg), .commit_data(commit_data),
    .commit_tag(commit_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int idx; logic [4:0] rd; bit rdy; logic [31:0] data; } ent_t;
  typedef struct { logic [4:0] rd; logic [31:0] data; logic [3:0] tag; } cmt_t;

  ent_t mq[$];   // live entries, oldest first
  int   m_tail;
  cmt_t sb[$];   // expected register-file writes
  int   errors = 0;
  int   checks = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [32:0] m_lookup(logic [3:0] t);
    if (t[3]) return 33'd0;
    if (cdb_valid && cdb_tag == t) return {1'b1, cdb_data};
    foreach (mq[i])
      if (mq[i].idx == int'(t[2:0]) && mq[i].rdy) return {1'b1, mq[i].data};
    return 33'd0;
  endfunction

  task automatic check_comb();
    logic [32:0] e;
    chk("rob_tail", rob_tail, m_tail);
    chk("rob_full", rob_full, mq.size() == 8);
    chk("rob_empty", rob_empty, mq.size() == 0);
    e = m_lookup(tag_check1); chk("tag1_ready", tag1_ready, e[32]); chk("rob_data1", rob_data1, e[31:0]);
    e = m_lookup(tag_check2); chk("tag2_ready", tag2_ready, e[32]); chk("rob_data2", rob_data2, e[31:0]);
    e = m_lookup(tag_checkd); chk("tagd_ready", tagd_ready, e[32]); chk("rob_datad", rob_datad, e[31:0]);
  endtask

  // Applies one clock edge to the model using the inputs presented in that cycle.
  task automatic model_edge();
    bit   was_full;
    ent_t c;
    if (flush) begin
      mq.delete();
      m_tail = 0;
      return;
    end
    was_full = (mq.size() == 8);
    if (mq.size() > 0 && mq[0].rdy) begin
      c = mq.pop_front();
      if (c.rd != 0) sb.push_back('{c.rd, c.data, 4'(c.idx)});
    end
    if (cdb_valid && !cdb_tag[3])
      foreach (mq[i])
        if (mq[i].idx == int'(cdb_tag[2:0])) begin
          mq[i].rdy  = 1'b1;
          mq[i].data = cdb_data;
        end
    if (dec_en && !was_full) begin
      mq.push_back('{m_tail, dec_rd, 1'b0, 32'd0});
      m_tail = (m_tail + 1) % 8;
    end
  endtask

  task automatic set_in(bit de, logic [4:0] rd, bit cv, logic [3:0] ct, logic [31:0] cd,
                        logic [3:0] t1, logic [3:0] t2, logic [3:0] td, bit fl);
    @(negedge clk);
    dec_en = de; dec_rd = rd; cdb_valid = cv; cdb_tag = ct; cdb_data = cd;
    tag_check1 = t1; tag_check2 = t2; tag_checkd = td; flush = fl;
    #1;
    check_comb();
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_edge();
  endtask

  task automatic cyc(bit de, logic [4:0] rd, bit cv, logic [3:0] ct, logic [31:0] cd,
                     logic [3:0] t1, logic [3:0] t2, logic [3:0] td, bit fl);
    set_in(de, rd, cv, ct, cd, t1, t2, td, fl);
    edge_step();
  endtask

  // Monitor: each retire predicted at an edge must appear on commit_* right after it.
  always @(negedge clk) begin
    if (rst) begin
      chk("commit_en", commit_en, sb.size() != 0);
      if (commit_en && sb.size() != 0) begin
        cmt_t e;
        e = sb.pop_front();
        chk("commit_reg", commit_reg, e.rd);
        chk("commit_data", commit_data, e.data);
        chk("commit_tag", commit_tag, e.tag);
      end else if (sb.size() != 0) begin
        void'(sb.pop_front());
      end
    end
  end

  function automatic logic [3:0] pick_tag();
    int j;
    if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
      j = $urandom_range(0, mq.size() - 1);
      return 4'(mq[j].idx);
    end
    return 4'($urandom_range(0, 15));
  endfunction

  task automatic rand_cycles(int n, int flush_odds);
    logic [3:0] ct;
    for (int k = 0; k < n; k++) begin
      ct = pick_tag();
      cyc($urandom_range(0, 2) != 0, 5'($urandom_range(0, 31)),
          $urandom_range(0, 2) != 0, ct, $urandom(),
          pick_tag(), ($urandom_range(0, 3) == 0) ? ct : pick_tag(), pick_tag(),
          flush_odds > 0 && $urandom_range(0, flush_odds - 1) == 0);
    end
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; dec_en = 1'b0; dec_rd = '0;
    cdb_valid = 1'b0; cdb_tag = 4'b1000; cdb_data = '0;
    tag_check1 = 4'b1000; tag_check2 = 4'b1000; tag_checkd = 4'b1000;
    m_tail = 0;
    #1;
    chk("rst_tail", rob_tail, 0);
    chk("rst_empty", rob_empty, 1);
    chk("rst_full", rob_full, 0);
    chk("rst_commit_en", commit_en, 0);
    chk("rst_commit_reg", commit_reg, 0);
    chk("rst_commit_data", commit_data, 0);
    chk("rst_commit_tag", commit_tag, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Fill all eight entries, then one blocked allocation.
    for (int i = 1; i <= 8; i++) cyc(1, 5'(i), 0, 4'b1000, 0, 4'b1000, 4'b1000, 4'b1000, 0);
    set_in(1, 5'd9, 0, 4'b1000, 0, 4'b1000, 4'b1000, 4'b1000, 0);
    chk("full_after_8", rob_full, 1);
    chk("tail_after_8", rob_tail, 0);
    edge_step();

    // Same-cycle CDB bypass, tagFree lookup, then out-of-order completion 2,1,0.
    set_in(0, 0, 1, 4'b0010, 32'hDEAD, 4'b0010, 4'b1000, 4'b0111, 0);
    chk("bypass_ready", tag1_ready, 1);
    chk("bypass_data", rob_data1, 32'hDEAD);
    chk("free_ready", tag2_ready, 0);
    chk("free_data", rob_data2, 0);
    edge_step();
    cyc(0, 0, 1, 4'b0001, 32'h1111, 4'b0010, 4'b0001, 4'b0000, 0);
    cyc(0, 0, 1, 4'b0000, 32'h0000_00AB, 4'b0000, 4'b0001, 4'b0010, 0);
    // Full with ready head: retire happens, allocation is refused this edge.
    cyc(1, 5'd20, 0, 4'b1000, 0, 4'b0000, 4'b0001, 4'b0010, 0);
    set_in(1, 5'd21, 0, 4'b1000, 0, 4'b0000, 4'b0001, 4'b0010, 0);
    chk("full_after_commit", rob_full, 0);
    chk("tail_before_alloc", rob_tail, 0);
    edge_step();
    set_in(0, 0, 0, 4'b1000, 0, 4'b1000, 4'b1000, 4'b1000, 0);
    chk("tail_after_alloc", rob_tail, 1);
    edge_step();

    // Complete everything still live so head wraps past entry 7.
    for (int i = 3; i <= 8; i++) cyc(0, 0, 1, 4'(i % 8), 32'(i * 16), 4'b1000, 4'b1000, 4'b1000, 0);
    repeat (4) cyc(0, 0, 0, 4'b1000, 0, 4'b1000, 4'b1000, 4'b1000, 0);

    // Flush with allocation and CDB in the same cycle.
    cyc(1, 5'd7, 1, 4'b0001, 32'h5A5A, 4'b1000, 4'b1000, 4'b1000, 1);
    set_in(1, 5'd3, 0, 4'b1000, 0, 4'b1000, 4'b1000, 4'b1000, 0);
    chk("flush_tail", rob_tail, 0);
    chk("flush_empty", rob_empty, 1);
    edge_step();

    rand_cycles(700, 48);

    // Asynchronous reset with five entries live.
    cyc(0, 0, 0, 4'b1000, 0, 4'b1000, 4'b1000, 4'b1000, 1);
    for (int i = 1; i <= 5; i++) cyc(1, 5'(i), 0, 4'b1000, 0, 4'b1000, 4'b1000, 4'b1000, 0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_tail", rob_tail, 0);
    chk("arst_empty", rob_empty, 1);
    chk("arst_commit_en", commit_en, 0);
    mq.delete(); m_tail = 0; sb.delete();
    dec_en = 1'b0; cdb_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    rand_cycles(300, 0);
    @(negedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
